// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS receive constants, FSM state type and transition-count helper.
// Imported by the channel receiver and its symbol decoder.
package tmds_pkg;

    // Control tokens as they appear in rawWord[9:0]; bit 0 is the first bit on the wire.
    localparam logic [9:0] TOKEN_C0 = 10'b1101010100;
    localparam logic [9:0] TOKEN_C1 = 10'b0010101011;
    localparam logic [9:0] TOKEN_C2 = 10'b0101010100;
    localparam logic [9:0] TOKEN_C3 = 10'b1010101011;

    // Non-token words with at least this many adjacent-bit transitions are illegal.
    localparam logic [3:0] ILLEGAL_TRANSITIONS = 4'd6;

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } rx_state_t;

    function automatic logic [3:0] transition_count(input logic [9:0] w);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 9; i++) begin
            n = n + {3'b000, w[i+1] ^ w[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_channel_rx_if.sv
// tmds_channel_rx_if: deserializer-side word input and decoded symbol output of one TMDS channel.
// rawValid qualifies rawWord for one cycle; there is no backpressure, every valid word is consumed.
interface tmds_channel_rx_if;

    logic [9:0] rawWord;
    logic       rawValid;
    logic       bitSlip;
    logic [7:0] dataByte;
    logic [1:0] ctrlBits;
    logic       dataEnable;
    logic       ctrlValid;
    logic       locked;
    logic       symbolError;

    modport master (
        output rawWord,
        output rawValid,
        input  bitSlip,
        input  dataByte,
        input  ctrlBits,
        input  dataEnable,
        input  ctrlValid,
        input  locked,
        input  symbolError
    );

    modport slave (
        input  rawWord,
        input  rawValid,
        output bitSlip,
        output dataByte,
        output ctrlBits,
        output dataEnable,
        output ctrlValid,
        output locked,
        output symbolError
    );

endinterface

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational classification of one 10-bit TMDS word into
// control token, data byte and illegal-word flag.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] word_i,
    output logic       is_token_o,
    output logic [1:0] ctrl_o,
    output logic [7:0] data_o,
    output logic       illegal_o
);

    logic [7:0] q_fix;
    logic [3:0] trans;

    always_comb begin
        is_token_o = 1'b1;
        ctrl_o     = 2'b00;
        case (word_i)
            TOKEN_C0: ctrl_o = 2'b00;
            TOKEN_C1: ctrl_o = 2'b01;
            TOKEN_C2: ctrl_o = 2'b10;
            TOKEN_C3: ctrl_o = 2'b11;
            default:  is_token_o = 1'b0;
        endcase
    end

    // q[9] marks an inverted payload; q[8] selects XOR versus XNOR chaining.
    always_comb begin
        q_fix     = word_i[9] ? ~word_i[7:0] : word_i[7:0];
        data_o    = '0;
        data_o[0] = q_fix[0];
        for (int i = 1; i < 8; i++) begin
            data_o[i] = word_i[8] ? (q_fix[i] ^ q_fix[i-1]) : ~(q_fix[i] ^ q_fix[i-1]);
        end
    end

    assign trans     = transition_count(word_i);
    assign illegal_o = !is_token_o && (trans >= ILLEGAL_TRANSITIONS);

endmodule

// File: rtl/tmds_channel_rx.sv
// tmds_channel_rx: TMDS word aligner (bit-slip search) and symbol decoder for one channel.
// Build option TMDS_RX_ERR_UNLOCK_EN: drop lock after ERR_LIMIT symbol errors without a token.
module tmds_channel_rx
    import tmds_pkg::*;
#(
    parameter int unsigned LOCK_COUNT    = 64,
    parameter int unsigned SEARCH_WINDOW = 2048,
    parameter int unsigned SLIP_SETTLE   = 8,
    parameter int unsigned LOSS_WINDOW   = 4096
`ifdef TMDS_RX_ERR_UNLOCK_EN
    ,
    parameter int unsigned ERR_LIMIT     = 4
`endif
) (
    input  logic                    pixelClock,
    input  logic                    reset,
    tmds_channel_rx_if.slave        bus,
    output rx_state_t               dbg_state_o
);

    localparam int unsigned GAP_SPAN = (SEARCH_WINDOW > LOSS_WINDOW) ? SEARCH_WINDOW : LOSS_WINDOW;
    localparam int unsigned RUN_W    = $clog2(LOCK_COUNT + 1);
    localparam int unsigned GAP_W    = $clog2(GAP_SPAN + 1);
    localparam int unsigned SET_W    = $clog2(SLIP_SETTLE + 1);

    localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(LOCK_COUNT);
    localparam logic [GAP_W-1:0] SEARCH_MAX  = GAP_W'(SEARCH_WINDOW);
    localparam logic [GAP_W-1:0] LOSS_MAX    = GAP_W'(LOSS_WINDOW);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SLIP_SETTLE - 1);

    logic       is_token;
    logic       illegal;
    logic [1:0] ctrl_code;
    logic [7:0] data_byte;

    tmds_symbol_decode u_decode (
        .word_i     (bus.rawWord),
        .is_token_o (is_token),
        .ctrl_o     (ctrl_code),
        .data_o     (data_byte),
        .illegal_o  (illegal)
    );

    rx_state_t        state_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;
    logic [SET_W-1:0] settle_q;
    logic [SET_W-1:0] settle_d;
    logic             bit_slip_q;
    logic             data_en_q;
    logic             ctrl_valid_q;
    logic             sym_err_q;
    logic [7:0]       data_byte_q;
    logic [1:0]       ctrl_bits_q;
    logic             lose_lock;

`ifdef TMDS_RX_ERR_UNLOCK_EN
    localparam int unsigned      ERR_W   = $clog2(ERR_LIMIT + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(ERR_LIMIT);

    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_d;
`endif

    // Counters saturate instead of wrapping; lose_lock is only consulted for non-token words.
    always_comb begin
        run_d    = (run_q == '1) ? run_q : run_q + 1'b1;
        gap_d    = (gap_q == '1) ? gap_q : gap_q + 1'b1;
        settle_d = settle_q + 1'b1;
`ifdef TMDS_RX_ERR_UNLOCK_EN
        err_d     = !illegal ? err_q : ((err_q == '1) ? err_q : err_q + 1'b1);
        lose_lock = (gap_d == LOSS_MAX) || (illegal && (err_d == ERR_MAX));
`else
        lose_lock = (gap_d == LOSS_MAX);
`endif
    end

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            state_q      <= ST_SEARCH;
            run_q        <= '0;
            gap_q        <= '0;
            settle_q     <= '0;
            bit_slip_q   <= 1'b0;
            data_en_q    <= 1'b0;
            ctrl_valid_q <= 1'b0;
            sym_err_q    <= 1'b0;
            data_byte_q  <= '0;
            ctrl_bits_q  <= '0;
`ifdef TMDS_RX_ERR_UNLOCK_EN
            err_q        <= '0;
`endif
        end else begin
            bit_slip_q   <= 1'b0;
            data_en_q    <= 1'b0;
            ctrl_valid_q <= 1'b0;
            sym_err_q    <= 1'b0;
            case (state_q)
                ST_SEARCH: begin
                    if (bus.rawValid) begin
                        if (is_token) begin
                            gap_q <= '0;
                            // The token that completes the run is already emitted as a control symbol.
                            if (run_d == RUN_MAX) begin
                                state_q      <= ST_LOCKED;
                                run_q        <= '0;
                                ctrl_valid_q <= 1'b1;
                                ctrl_bits_q  <= ctrl_code;
                            end else begin
                                run_q <= run_d;
                            end
                        end else begin
                            run_q <= '0;
                            if (gap_d == SEARCH_MAX) begin
                                state_q    <= ST_SLIP_WAIT;
                                gap_q      <= '0;
                                bit_slip_q <= 1'b1;
                            end else begin
                                gap_q <= gap_d;
                            end
                        end
                    end
                end
                ST_SLIP_WAIT: begin
                    // Deserializer output is untrustworthy while it realigns, so time in cycles.
                    if (settle_q == SETTLE_LAST) begin
                        state_q  <= ST_SEARCH;
                        settle_q <= '0;
                    end else begin
                        settle_q <= settle_d;
                    end
                end
                ST_LOCKED: begin
                    if (bus.rawValid) begin
                        if (is_token) begin
                            gap_q        <= '0;
                            ctrl_valid_q <= 1'b1;
                            ctrl_bits_q  <= ctrl_code;
`ifdef TMDS_RX_ERR_UNLOCK_EN
                            err_q        <= '0;
`endif
                        end else begin
                            sym_err_q <= illegal;
                            if (lose_lock) begin
                                state_q <= ST_SEARCH;
                                gap_q   <= '0;
`ifdef TMDS_RX_ERR_UNLOCK_EN
                                err_q   <= '0;
`endif
                            end else begin
                                gap_q       <= gap_d;
                                data_en_q   <= 1'b1;
                                data_byte_q <= data_byte;
`ifdef TMDS_RX_ERR_UNLOCK_EN
                                err_q       <= err_d;
`endif
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_SEARCH;
                end
            endcase
        end
    end

    assign bus.bitSlip     = bit_slip_q;
    assign bus.dataByte    = data_byte_q;
    assign bus.ctrlBits    = ctrl_bits_q;
    assign bus.dataEnable  = data_en_q;
    assign bus.ctrlValid   = ctrl_valid_q;
    assign bus.locked      = (state_q == ST_LOCKED);
    assign bus.symbolError = sym_err_q;
    assign dbg_state_o     = state_q;

endmodule

// File: doc/tmds_channel_rx.md
# tmds_channel_rx

Receive-side TMDS channel decoder: the counterpart of the TMDS encoder inside `hdmi_tx`. It takes one deserialized 10-bit TMDS word per pixel clock, finds word alignment by steering an external deserializer with bit-slip pulses, and decodes each word into an 8-bit data byte or a 2-bit control code with a data-enable flag. One instance sits behind each deserialized HDMI input channel (blue channel carries hSync/vSync in `ctrlBits`) and feeds a downstream pixel/timing recovery block.

## Interface
- `LOCK_COUNT`, 64 — consecutive control tokens required to declare lock (≥2).
- `SEARCH_WINDOW`, 2048 — words without any control token before a bit-slip is issued.
- `SLIP_SETTLE`, 8 — cycles ignored after a bit-slip pulse.
- `LOSS_WINDOW`, 4096 — words without a control token while locked before lock is dropped.
- `ERR_LIMIT`, 4 — symbol errors since last control token that drop lock (macro-dependent).
- `pixelClock` in 1 — single clock for all logic.
- `reset` in 1 — synchronous, active-high.
- `rawWord` in 10 — deserialized word; bit 0 = first bit on the wire.
- `rawValid` in 1 — `rawWord` valid this cycle; counters and FSM advance only when high.
- `bitSlip` out 1 — one-cycle request to the deserializer to shift alignment by one bit.
- `dataByte` out 8 — decoded data byte.
- `ctrlBits` out 2 — decoded control code {C1,C0}.
- `dataEnable` out 1 — `dataByte` is a valid video/data symbol.
- `ctrlValid` out 1 — `ctrlBits` is a valid control token.
- `locked` out 1 — alignment achieved.
- `symbolError` out 1 — one-cycle pulse on an illegal word while locked.

## Operation
- Control tokens (rawWord[9:0]): 10'b1101010100→00, 10'b0010101011→01, 10'b0101010100→10, 10'b1010101011→11.
- Data decode: if q[9], invert q[7:0] first; d[0]=q[0]; d[i]=q[i]^q[i-1] when q[8]=1, else ~(q[i]^q[i-1]), i=1..7.
- Transition count = number of unequal adjacent pairs in rawWord[9:0] (0..9). Illegal word: count ≥6 and not a control token.
- FSM states SEARCH, SLIP_WAIT, LOCKED; reset → SEARCH, all counters 0.
- SEARCH: token increments run counter, non-token clears it; run reaching `LOCK_COUNT` → LOCKED. Separate gap counter counts words since last token; reaching `SEARCH_WINDOW` → pulse `bitSlip`, clear counters, → SLIP_WAIT.
- SLIP_WAIT: counts `SLIP_SETTLE` cycles (regardless of `rawValid`), words ignored, then → SEARCH.
- LOCKED: gap counter reaching `LOSS_WINDOW` → SEARCH. Illegal word pulses `symbolError` and increments error counter; any token clears error counter.
- Token and illegal word in same cycle impossible; token has priority in all counters.
- Outputs when not LOCKED or `rawValid`=0: `dataEnable`=0, `ctrlValid`=0, `dataByte`/`ctrlBits` hold last value.
- In LOCKED with valid word: token → `ctrlValid`=1, `ctrlBits` updated; otherwise `dataEnable`=1, `dataByte` updated (also for illegal words).

## Timing
- Reset values: `bitSlip`=0, `dataByte`=0, `ctrlBits`=0, `dataEnable`=0, `ctrlValid`=0, `locked`=0, `symbolError`=0.
- Decode latency 1 cycle: word sampled at edge N appears on outputs after edge N+1.
- `locked` rises the cycle after the `LOCK_COUNT`th token is sampled; that token itself is output with `ctrlValid`=1.
- `locked` falls the cycle after the losing condition; that word's output is suppressed.
- `bitSlip` is exactly one cycle wide; at most one pulse per `SLIP_SETTLE`+1 cycles.
- Counters saturate, never wrap; reset mid-operation returns to SEARCH next cycle.

## Configuration
- `TMDS_RX_ERR_UNLOCK_EN` defined: error counter reaching `ERR_LIMIT` → SEARCH.
- Undefined: no error counter; `symbolError` still pulses, lock lost only via `LOSS_WINDOW`.

## Structure
- Shared package `tmds_pkg`: four control-token constants, FSM state typedef, transition-count threshold constant.
- Sub-module `tmds_symbol_decode` (combinational): token match, control code, data byte, illegal flag.

## Test plan
- 64 consecutive 10'b1101010100 after reset → `locked`=1 one cycle after 64th; `ctrlValid`=1, `ctrlBits`=00.
- Locked, word 10'b0100000000 then 10'b1000000000 (q8=1/q9=1 cases) → `dataByte` 8'h00 and 8'hFF, `dataEnable`=1.
- Stream rotated by 3 bits → `bitSlip` pulse every `SEARCH_WINDOW`+`SLIP_SETTLE` words; after 3 model slips → lock.
- Locked, 4096 data words, no tokens → `locked` falls; `dataEnable`=0 thereafter.
- Locked, 4 words 10'b1010101010 → 4 `symbolError` pulses; with macro lock drops after 4th, without stays locked.
- `reset` asserted while locked → next cycle all outputs at reset values, state SEARCH.
